// File: rtl/dmem_stall_resp.sv
// dmem_stall_resp
//   Multi-cycle data-memory responder for the processor data port. It accepts
//   one read or write at a time from IDLE. It holds the initiator with Stall
//   for LATENCY cycles and completes with a one-cycle Done pulse. Odd byte
//   addresses and simultaneous Rd/Wr requests are reported on err.
//
// Parameters
//   LATENCY  cycles from accept to Done (1..15)
//   AW       word-array address width; array is indexed by Addr[AW:1]
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset (also clears the array)
//   Rd, Wr   request strobes; exactly one high requests an access
//   Addr     16-bit byte address; bits above AW are ignored
//   DataIn   write data
//   DataOut  read data, non-zero only in the Done cycle of an aligned read
//   Done     completion pulse
//   Stall    access outstanding and not completing this cycle
//   err      misaligned completion, or Rd&Wr rejection in IDLE
module dmem_stall_resp #(
    parameter int LATENCY = 4,
    parameter int AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic            op_q,    op_d;     // 1 = write
    logic [AW-1:0]   idx_q,   idx_d;
    logic [15:0]     data_q,  data_d;
    logic            mis_q,   mis_d;

    logic [15:0]     mem_q [2**AW];
    logic            wr_en;

    // Address bits above the word index alias onto the array.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^Addr[15:AW+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mis_d   = mis_q;
        DataOut = '0;
        Done    = 1'b0;
        Stall   = 1'b0;
        err     = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Rd ^ Wr) begin
                    // Accept: stall is raised in this same cycle.
                    Stall   = 1'b1;
                    op_d    = Wr;
                    idx_d   = Addr[AW:1];
                    data_d  = DataIn;
                    mis_d   = Addr[0];
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end else if (Rd && Wr) begin
                    // Ambiguous request: flag it and do nothing.
                    err = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    Stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    Done    = 1'b1;
                    err     = mis_q;
                    if (!op_q && !mis_q)
                        DataOut = mem_q[idx_q];
                    // A misaligned write is dropped; it only reports err.
                    wr_en   = op_q && !mis_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
        end
    end

    // Reset wins over a completing write, so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++)
                mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_dmem_stall_resp.sv
// Directed bench for dmem_stall_resp. One instance runs at LATENCY=4 and a
// second at LATENCY=1. Both share the request inputs; each test observes only
// the instance it targets.
module tb_dmem_stall_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        Rd, Wr;
    logic [15:0] Addr, DataIn;
    logic [15:0] dout4, dout1;
    logic        done4, stall4, err4;
    logic        done1, stall1, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_stall_resp #(.LATENCY(4), .AW(10)) u_dut4 (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(dout4), .Done(done4), .Stall(stall4), .err(err4)
    );

    dmem_stall_resp #(.LATENCY(1), .AW(10)) u_dut1 (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(dout1), .Done(done1), .Stall(stall1), .err(err1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    endtask

    // Full access on the LATENCY=4 instance with per-cycle output checks.
    task automatic acc4(input string tag, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_dout,
                        input logic exp_err);
        Rd = !wr; Wr = wr; Addr = a; DataIn = d;
        #1;
        chk({tag, ".acc_stall"}, 16'(stall4), 16'd1);
        chk({tag, ".acc_done"},  16'(done4),  16'd0);
        cyc();
        idle_in();
        for (int i = 1; i < 4; i++) begin
            #1;
            chk({tag, ".busy_stall"}, 16'(stall4), 16'd1);
            chk({tag, ".busy_done"},  16'(done4),  16'd0);
            cyc();
        end
        #1;
        chk({tag, ".done"},  16'(done4),  16'd1);
        chk({tag, ".stall"}, 16'(stall4), 16'd0);
        chk({tag, ".err"},   16'(err4),   16'(exp_err));
        chk({tag, ".dout"},  dout4,       exp_dout);
        cyc();
        #1;
        chk({tag, ".after_done"}, 16'(done4), 16'd0);
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst.dout",  dout4,        16'h0000);
        chk("rst.done",  16'(done4),   16'd0);
        chk("rst.stall", 16'(stall4),  16'd0);
        chk("rst.err",   16'(err4),    16'd0);
        cyc();

        // Basic read of a cleared word.
        acc4("rd10", 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);

        // Write then read back; neighbour untouched.
        acc4("wr20", 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
        acc4("rd20", 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0);
        acc4("rd22", 1'b0, 16'h0022, 16'h0000, 16'h0000, 1'b0);

        // Rejection of Rd&Wr leaves the word intact.
        acc4("wr30", 1'b1, 16'h0030, 16'h7777, 16'h0000, 1'b0);
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hDEAD;
        #1;
        chk("rej.err",   16'(err4),   16'd1);
        chk("rej.stall", 16'(stall4), 16'd0);
        chk("rej.done",  16'(done4),  16'd0);
        cyc();
        idle_in();
        #1;
        chk("rej.next_err",   16'(err4),   16'd0);
        chk("rej.next_stall", 16'(stall4), 16'd0);
        chk("rej.next_done",  16'(done4),  16'd0);
        cyc();
        acc4("rd30", 1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0);

        // Misaligned write is flagged and dropped.
        acc4("wr40", 1'b1, 16'h0040, 16'h1111, 16'h0000, 1'b0);
        acc4("wr41", 1'b1, 16'h0041, 16'h1234, 16'h0000, 1'b1);
        acc4("rd40", 1'b0, 16'h0040, 16'h0000, 16'h1111, 1'b0);
        acc4("rd42", 1'b0, 16'h0042, 16'h0000, 16'h0000, 1'b0);

        // Address wrap above AW.
        acc4("wr800", 1'b1, 16'h0800, 16'h4242, 16'h0000, 1'b0);
        acc4("rd000", 1'b0, 16'h0000, 16'h0000, 16'h4242, 1'b0);

        // Reset two cycles after accepting a write aborts it.
        Wr = 1'b1; Addr = 16'h0050; DataIn = 16'h5555;
        cyc();
        idle_in();
        #1;
        chk("abort.busy_stall", 16'(stall4), 16'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("abort.done",  16'(done4),  16'd0);
        chk("abort.stall", 16'(stall4), 16'd0);
        chk("abort.err",   16'(err4),   16'd0);
        chk("abort.dout",  dout4,       16'h0000);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort.no_done", 16'(done4), 16'd0);
            cyc();
        end
        acc4("rd50", 1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b0);
        acc4("rd20_clr", 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);

        // LATENCY=1 instance, back-to-back with strobes held through Done.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        Wr = 1'b1; Addr = 16'h0060; DataIn = 16'hA5A5;
        #1;
        chk("l1.wr_acc_stall", 16'(stall1), 16'd1);
        chk("l1.wr_acc_done",  16'(done1),  16'd0);
        cyc();
        #1;
        chk("l1.wr_done",  16'(done1),  16'd1);
        chk("l1.wr_stall", 16'(stall1), 16'd0);
        chk("l1.wr_err",   16'(err1),   16'd0);
        chk("l1.wr_dout",  dout1,       16'h0000);
        cyc();
        Wr = 1'b0; Rd = 1'b1;
        #1;
        chk("l1.rd_acc_stall", 16'(stall1), 16'd1);
        chk("l1.rd_acc_done",  16'(done1),  16'd0);
        cyc();
        #1;
        chk("l1.rd_done",  16'(done1),  16'd1);
        chk("l1.rd_stall", 16'(stall1), 16'd0);
        chk("l1.rd_dout",  dout1,       16'hA5A5);
        cyc();
        // Rd still held: a fresh accept follows immediately.
        #1;
        chk("l1.re_acc_stall", 16'(stall1), 16'd1);
        chk("l1.re_acc_done",  16'(done1),  16'd0);
        cyc();
        #1;
        chk("l1.re_done", 16'(done1), 16'd1);
        chk("l1.re_dout", dout1,      16'hA5A5);
        cyc();
        idle_in();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
